// File: rtl/alveo_hls4ml_dense_acc_requant.sv
// Dense-layer accumulator: bias + N_IN products per neuron, then
// round-half-up shift, saturation to OUT_W and a valid/ready output.
module alveo_hls4ml_dense_acc_requant #(
  parameter int PROD_W = 26,
  parameter int ACC_W  = 32,
  parameter int N_IN   = 16,
  parameter int N_OUT  = 8,
  parameter int SHIFT  = 10,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic signed [ACC_W-1:0]  bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    ovf
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);
  localparam logic [NW-1:0] IDX_LAST = NW'(N_OUT - 1);
  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] SMAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACCUM,
    S_REQ,
    S_OUT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [NW-1:0]           r_nidx;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_sum;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_ovf;
  logic signed [OUT_W-1:0] r_out_data;

  logic                    w_accept;
  logic                    w_cnt_last;
  logic                    w_out_hs;
  logic                    w_clip;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_q;
  logic signed [OUT_W-1:0] w_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_ACCUM: if (w_accept && w_cnt_last) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_OUT;
      S_OUT:   if (w_out_hs) w_state_nxt = S_ACCUM;
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_ACCUM) && !reset;
  end

  assign w_accept   = in_valid && in_ready;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_out_hs   = (r_state == S_OUT) && r_out_valid && out_ready;

  // First product of a neuron seeds the sum with the bias.
  assign w_prod_ext =
    {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
  assign w_acc_nxt  =
    ((r_cnt == '0) ? bias : r_acc) + w_prod_ext;

  // One guard bit so the rounding offset cannot wrap.
  assign w_rnd  = {r_sum[ACC_W-1], r_sum} + RND;
  assign w_q    = w_rnd >>> SHIFT;
  assign w_clip = (w_q > SMAX) || (w_q < SMIN);
  assign w_sat  = (w_q > SMAX) ? SMAX[OUT_W-1:0] :
                  (w_q < SMIN) ? SMIN[OUT_W-1:0] :
                                 w_q[OUT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_nidx      <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        if (w_cnt_last) begin
          r_cnt <= '0;
          r_sum <= w_acc_nxt;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (r_state == S_REQ) begin
        r_out_data  <= w_sat;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_nidx == IDX_LAST);
        if (w_clip) r_ovf <= 1'b1;
      end
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_nidx      <= (r_nidx == IDX_LAST) ? '0 : r_nidx + NW'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alveo_hls4ml_dense_acc_requant.sv
// Randomised bench for the dense accumulator/requantiser against an
// arithmetic reference model (N_IN=4, N_OUT=3, SHIFT=10).
module tb_alveo_hls4ml_dense_acc_requant;

  localparam int PW = 26;
  localparam int AW = 32;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int SH = 10;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_data;
  logic signed [AW-1:0] bias;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_last;
  logic                 ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int m_idx  = 0;
  bit m_ovf  = 1'b0;

  alveo_hls4ml_dense_acc_requant #(
    .PROD_W(PW), .ACC_W(AW), .N_IN(NI),
    .N_OUT(NO), .SHIFT(SH), .OUT_W(OW)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  // Exact sum, wrap to AW bits, floor((s + 2^(SH-1)) / 2^SH), clamp.
  function automatic longint ref_q(input longint b, input int p[$],
                                   output bit clip);
    longint s, r, d, q, lim;
    logic signed [AW-1:0] w;
    s = b;
    foreach (p[i]) s += p[i];
    w = s[AW-1:0];
    s = w;
    d = longint'(1) << SH;
    r = s + d / 2;
    q = r / d;
    if ((r % d != 0) && (r < 0)) q -= 1;
    lim  = longint'(1) << (OW - 1);
    clip = 1'b0;
    if (q > lim - 1) begin q = lim - 1; clip = 1'b1; end
    if (q < -lim)    begin q = -lim;    clip = 1'b1; end
    return q;
  endfunction

  function automatic int rprod();
    logic signed [PW-1:0] t;
    t = PW'($urandom);
    return int'(t);
  endfunction

  task automatic feed(input int b, input int p[$], input int n);
    int k = 0;
    int g = 0;
    bit acc;
    while (k < n && g < 100) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? PW'(p[k]) : PW'($urandom);
      bias     = (k == 0) ? AW'(b) : AW'($urandom);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
      g++;
    end
    #1 in_valid = 1'b0;
    chk("accept_count", k, n);
  endtask

  task automatic run_neuron(input int b, input int p[$],
                            input int stall, output longint got);
    longint exp;
    bit clip, last;
    feed(b, p, NI);
    exp   = ref_q(b, p, clip);
    m_ovf = m_ovf | clip;
    last  = (m_idx == NO - 1);
    @(negedge clk);
    chk("req_valid", out_valid, 0);
    chk("req_ready", in_ready, 0);
    out_ready = (stall == 0);
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    chk("out_last", out_last, last);
    chk("ovf", ovf, m_ovf);
    chk("out_ready_low", in_ready, 0);
    got = out_data;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data  = PW'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_last", out_last, last);
      chk("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    out_ready = 1'(($urandom_range(0, 1)));
    m_idx = (m_idx == NO - 1) ? 0 : m_idx + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     p[$];
    longint got;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    bias      = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);

    p = {1024, 2048, -512, 512};
    run_neuron(0, p, 0, got);
    chk("basic", got, 3);
    p = {0, 0, 0, 0};
    run_neuron(1536, p, 0, got);
    chk("round_pos", got, 2);
    run_neuron(-1536, p, 0, got);
    chk("round_neg", got, -1);
    run_neuron(1535, p, 0, got);
    chk("round_below", got, 1);

    p = {1 << 24, 1 << 24, 1 << 24, 1 << 24};
    run_neuron(0, p, 0, got);
    chk("sat_pos", got, 32767);
    chk("sat_ovf", ovf, 1);
    p = {-(1 << 25), -(1 << 25), -(1 << 25), -(1 << 25)};
    run_neuron(0, p, 0, got);
    chk("sat_neg", got, -32768);
    p = {100, 200, 300, 400};
    run_neuron(0, p, 0, got);
    chk("ovf_sticky", ovf, 1);

    p = {5000, -3000, 7000, 1000};
    run_neuron(-2000, p, 5, got);
    chk("bp_sum", got, 8);

    for (int n = 0; n < 20; n++) begin
      p = {};
      for (int i = 0; i < NI; i++) p.push_back(rprod());
      run_neuron(int'($urandom), p, $urandom_range(0, 3), got);
    end

    p = {777, 888, 0, 0};
    feed(0, p, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    m_idx = 0;
    m_ovf = 1'b0;
    p = {1024, 1024, 1024, 1024};
    run_neuron(0, p, 0, got);
    chk("after_rst", got, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
